// File: rtl/rv32_id_ex_operand_stage_if.sv
// ID/EX operand-stage bundle: decoded ID fields, hold/bubble controls, retiring-producer forwards, EX operands.
// slave is the stage's view; master is the driver/observer view (hazard unit, ID, EX).
interface rv32_id_ex_operand_stage_if #(
  parameter int XLEN    = 32,
  parameter int OPSEL_W = 5,
  parameter int REGA_W  = 5
);
  logic               id_valid;
  logic [XLEN-1:0]    id_pc;
  logic [XLEN-1:0]    id_rs1_data;
  logic [XLEN-1:0]    id_rs2_data;
  logic [XLEN-1:0]    id_imm;
  logic [REGA_W-1:0]  id_rs1_addr;
  logic [REGA_W-1:0]  id_rs2_addr;
  logic [REGA_W-1:0]  id_rd_addr;
  logic               id_rd_we;
  logic [OPSEL_W-1:0] id_alu_opsel;
  logic               id_opa_pc;
  logic               id_opb_imm;
  logic               stall;
  logic               flush;
  logic               exmem_rd_we;
  logic [REGA_W-1:0]  exmem_rd_addr;
  logic [XLEN-1:0]    exmem_result;
  logic               memwb_rd_we;
  logic [REGA_W-1:0]  memwb_rd_addr;
  logic [XLEN-1:0]    memwb_result;
  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc;
  logic [XLEN-1:0]    ex_opA;
  logic [XLEN-1:0]    ex_opB;
  logic [XLEN-1:0]    ex_store_data;
  logic [OPSEL_W-1:0] ex_alu_opsel;
  logic [REGA_W-1:0]  ex_rd_addr;
  logic               ex_rd_we;

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_rd_we,
           id_alu_opsel, id_opa_pc, id_opb_imm, stall, flush,
           exmem_rd_we, exmem_rd_addr, exmem_result,
           memwb_rd_we, memwb_rd_addr, memwb_result,
    output ex_valid, ex_pc, ex_opA, ex_opB, ex_store_data,
           ex_alu_opsel, ex_rd_addr, ex_rd_we
  );

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_rd_we,
           id_alu_opsel, id_opa_pc, id_opb_imm, stall, flush,
           exmem_rd_we, exmem_rd_addr, exmem_result,
           memwb_rd_we, memwb_rd_addr, memwb_result,
    input  ex_valid, ex_pc, ex_opA, ex_opB, ex_store_data,
           ex_alu_opsel, ex_rd_addr, ex_rd_we
  );
endinterface

// File: rtl/rv32_id_ex_operand_stage.sv
// ID/EX register with EX-side operand forwarding: 1-cycle ID->EX, operand mux combinational on live forwards.
// Priority flush > stall > load; stall holds every field, flush inserts a bubble.
module rv32_id_ex_operand_stage #(
  parameter int XLEN    = 32,
  parameter int OPSEL_W = 5,
  parameter int REGA_W  = 5
) (
  input logic                         clk,
  input logic                         rst,
  rv32_id_ex_operand_stage_if.slave   bus
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [REGA_W-1:0]  rs1_addr;
    logic [REGA_W-1:0]  rs2_addr;
    logic [REGA_W-1:0]  rd_addr;
    logic               rd_we;
    logic [OPSEL_W-1:0] alu_opsel;
    logic               opa_pc;
    logic               opb_imm;
  } idex_t;

  idex_t idex_q, idex_d;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    idex_d = idex_q;
    if (bus.flush) begin
      idex_d = '0;
    end else if (!bus.stall) begin
      idex_d.valid     = bus.id_valid;
      idex_d.pc        = bus.id_pc;
      idex_d.rs1_data  = bus.id_rs1_data;
      idex_d.rs2_data  = bus.id_rs2_data;
      idex_d.imm       = bus.id_imm;
      idex_d.rs1_addr  = bus.id_rs1_addr;
      idex_d.rs2_addr  = bus.id_rs2_addr;
      idex_d.rd_addr   = bus.id_rd_addr;
      idex_d.rd_we     = bus.id_rd_we & bus.id_valid;
      idex_d.alu_opsel = bus.id_alu_opsel;
      idex_d.opa_pc    = bus.id_opa_pc;
      idex_d.opb_imm   = bus.id_opb_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  // Forwarding uses the live producer ports, so a stalled instruction still picks up newer results.
  always_comb begin
    fwd_rs1 = idex_q.rs1_data;
    if (bus.exmem_rd_we && (bus.exmem_rd_addr == idex_q.rs1_addr) && (idex_q.rs1_addr != '0)) begin
      fwd_rs1 = bus.exmem_result;
    end else if (bus.memwb_rd_we && (bus.memwb_rd_addr == idex_q.rs1_addr) && (idex_q.rs1_addr != '0)) begin
      fwd_rs1 = bus.memwb_result;
    end
  end

  always_comb begin
    fwd_rs2 = idex_q.rs2_data;
    if (bus.exmem_rd_we && (bus.exmem_rd_addr == idex_q.rs2_addr) && (idex_q.rs2_addr != '0)) begin
      fwd_rs2 = bus.exmem_result;
    end else if (bus.memwb_rd_we && (bus.memwb_rd_addr == idex_q.rs2_addr) && (idex_q.rs2_addr != '0)) begin
      fwd_rs2 = bus.memwb_result;
    end
  end

  assign bus.ex_valid      = idex_q.valid;
  assign bus.ex_pc         = idex_q.pc;
  assign bus.ex_opA        = idex_q.opa_pc  ? idex_q.pc  : fwd_rs1;
  assign bus.ex_opB        = idex_q.opb_imm ? idex_q.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_alu_opsel  = idex_q.alu_opsel;
  assign bus.ex_rd_addr    = idex_q.rd_addr;
  assign bus.ex_rd_we      = idex_q.rd_we & idex_q.valid;

endmodule

// File: tb/tb_rv32_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage: reset, load, forwarding priority, x0, PC/imm select, stall, flush.
module tb_rv32_id_ex_operand_stage;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rv32_id_ex_operand_stage_if #(.XLEN(32), .OPSEL_W(5), .REGA_W(5)) bus ();

  rv32_id_ex_operand_stage #(.XLEN(32), .OPSEL_W(5), .REGA_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_drive(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1a, input logic [31:0] rs1d,
                          input logic [4:0] rs2a, input logic [31:0] rs2d,
                          input logic [31:0] imm, input logic [4:0] rd, input logic rdwe,
                          input logic [4:0] opsel, input logic opa_pc, input logic opb_imm);
    bus.id_valid     = v;
    bus.id_pc        = pc;
    bus.id_rs1_addr  = rs1a;
    bus.id_rs1_data  = rs1d;
    bus.id_rs2_addr  = rs2a;
    bus.id_rs2_data  = rs2d;
    bus.id_imm       = imm;
    bus.id_rd_addr   = rd;
    bus.id_rd_we     = rdwe;
    bus.id_alu_opsel = opsel;
    bus.id_opa_pc    = opa_pc;
    bus.id_opb_imm   = opb_imm;
  endtask

  task automatic fwd_drive(input logic ewe, input logic [4:0] ea, input logic [31:0] er,
                           input logic mwe, input logic [4:0] ma, input logic [31:0] mr);
    bus.exmem_rd_we   = ewe;
    bus.exmem_rd_addr = ea;
    bus.exmem_result  = er;
    bus.memwb_rd_we   = mwe;
    bus.memwb_rd_addr = ma;
    bus.memwb_result  = mr;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    id_drive(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    fwd_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #12;
    chk("rst_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("rst_rd_we", {31'b0, bus.ex_rd_we}, 32'h0);
    chk("rst_opsel", {27'b0, bus.ex_alu_opsel}, 32'h0);
    chk("rst_pc",    bus.ex_pc, 32'h0);
    chk("rst_opA",   bus.ex_opA, 32'h0);
    rst = 1'b0;

    // plain load, no forwards
    id_drive(1'b1, 32'h100, 5'd5, 32'h10, 5'd6, 32'h20, 32'h0, 5'd7, 1'b1, 5'd1, 1'b0, 1'b0);
    tick();
    chk("ld_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("ld_opA",   bus.ex_opA, 32'h10);
    chk("ld_opB",   bus.ex_opB, 32'h20);
    chk("ld_opsel", {27'b0, bus.ex_alu_opsel}, 32'h1);
    chk("ld_rd",    {27'b0, bus.ex_rd_addr}, 32'h7);
    chk("ld_rd_we", {31'b0, bus.ex_rd_we}, 32'h1);
    chk("ld_pc",    bus.ex_pc, 32'h100);
    chk("ld_st",    bus.ex_store_data, 32'h20);

    // both producers target x5: EX/MEM wins, then MEM/WB alone
    bus.stall = 1'b1;
    fwd_drive(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
    #1;
    chk("fwd_exmem_prio", bus.ex_opA, 32'hAA);
    chk("fwd_opB_untouched", bus.ex_opB, 32'h20);
    bus.exmem_rd_we = 1'b0;
    #1;
    chk("fwd_memwb", bus.ex_opA, 32'hBB);
    fwd_drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h55);
    #1;
    chk("fwd_memwb_rs2", bus.ex_opB, 32'h55);
    fwd_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    bus.stall = 1'b0;

    // x0 never forwards; rd_we without valid is dropped
    id_drive(1'b0, 32'h104, 5'd0, 32'h0, 5'd6, 32'h20, 32'h0, 5'd3, 1'b1, 5'd2, 1'b0, 1'b0);
    fwd_drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0);
    tick();
    chk("x0_opA", bus.ex_opA, 32'h0);
    chk("inval_rd_we", {31'b0, bus.ex_rd_we}, 32'h0);
    chk("inval_valid", {31'b0, bus.ex_valid}, 32'h0);

    // PC/imm operands; store data still forwarded rs2
    id_drive(1'b1, 32'h400, 5'd5, 32'h10, 5'd6, 32'h20, 32'hFFFFF000, 5'd8, 1'b1, 5'd2, 1'b1, 1'b1);
    fwd_drive(1'b1, 5'd6, 32'h77, 1'b0, 5'd0, 32'h0);
    tick();
    chk("pc_opA", bus.ex_opA, 32'h400);
    chk("imm_opB", bus.ex_opB, 32'hFFFFF000);
    chk("imm_st", bus.ex_store_data, 32'h77);

    // stall two cycles with new ID contents
    bus.stall = 1'b1;
    id_drive(1'b1, 32'h800, 5'd9, 32'h99, 5'd10, 32'h11, 32'h4, 5'd11, 1'b1, 5'd3, 1'b0, 1'b0);
    tick();
    tick();
    chk("stall_pc", bus.ex_pc, 32'h400);
    chk("stall_opsel", {27'b0, bus.ex_alu_opsel}, 32'h2);
    chk("stall_rd", {27'b0, bus.ex_rd_addr}, 32'h8);
    chk("stall_opA", bus.ex_opA, 32'h400);
    bus.exmem_result = 32'h99;
    #1;
    chk("stall_fwd_st", bus.ex_store_data, 32'h99);

    // stall and flush together: bubble
    bus.flush = 1'b1;
    tick();
    chk("flush_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("flush_rd_we", {31'b0, bus.ex_rd_we}, 32'h0);
    chk("flush_opsel", {27'b0, bus.ex_alu_opsel}, 32'h0);
    chk("flush_pc", bus.ex_pc, 32'h0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    fwd_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // async reset mid-run clears outputs before the next edge
    id_drive(1'b1, 32'h200, 5'd1, 32'h12, 5'd2, 32'h34, 32'h0, 5'd4, 1'b1, 5'd6, 1'b0, 1'b0);
    tick();
    chk("pre_rst_valid", {31'b0, bus.ex_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("mid_rst_rd_we", {31'b0, bus.ex_rd_we}, 32'h0);
    chk("mid_rst_pc", bus.ex_pc, 32'h0);
    chk("mid_rst_opA", bus.ex_opA, 32'h0);
    chk("mid_rst_opsel", {27'b0, bus.ex_alu_opsel}, 32'h0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
